// File: rtl/access_pkg.sv
// Shared types and constants for the access-code entry front end.
package access_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam int CODE_W     = 18;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int OP_W       = 2;

    // Only the first three digits need holding; the fourth goes straight into the word.
    localparam int ACC_W = DIGIT_W * (NUM_DIGITS - 1);

    localparam logic [OP_W-1:0] OP_LOGIN  = 2'b00;
    localparam logic [OP_W-1:0] OP_CHANGE = 2'b01;
    localparam logic [OP_W-1:0] OP_LOGOUT = 2'b10;
    localparam logic [OP_W-1:0] OP_RSVD   = 2'b11;

    // Packs op code, the three held digits and the final digit into one code word.
    function automatic logic [CODE_W-1:0] build_word(
        input logic [OP_W-1:0]    op,
        input logic [ACC_W-1:0]   held,
        input logic [DIGIT_W-1:0] last
    );
        return {op, held, last};
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Loadable down-counter; done is asserted while enabled and the count has run out.
module entry_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    // Reload on request, otherwise count down while enabled and stop at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = en && (count == '0);

endmodule

// File: rtl/access_code_entry.sv
// Collects four digits plus an op code and emits one registered code word with a load strobe.
module access_code_entry
    import access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned HOLDOFF_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic              digit_load,
    input  logic [OP_W-1:0]   op_sel,
    input  logic              clear,
    output logic [CODE_W-1:0] _Data_Out,
    output logic              _Data_Out_Load,
    output logic [2:0]        digit_count,
    output logic              entry_active,
    output logic              timeout_flag
);

    // Timers count down to zero, so both are preloaded with one less than the cycle budget.
    localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  HOLDOFF_LOAD = 8'(HOLDOFF_CYCLES - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;

    logic digit_accept;
    logic idle_load;
    logic idle_en;
    logic idle_done;
    logic hold_load;
    logic hold_en;
    logic hold_done;

    assign digit_accept = digit_load && !clear && ((state == IDLE) || (state == COLLECT));
    assign idle_load    = digit_accept;
    assign idle_en      = (state == COLLECT);
    assign hold_load    = (state == EMIT);
    assign hold_en      = (state == HOLDOFF);

    entry_timer #(.W(32)) u_idle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (idle_load),
        .load_value (TIMEOUT_LOAD),
        .en         (idle_en),
        .done       (idle_done)
    );

    entry_timer #(.W(8)) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .load_value (HOLDOFF_LOAD),
        .en         (hold_en),
        .done       (hold_done)
    );

    // Entry FSM: clear beats a digit, a digit beats timeout, and the word register only changes on a full entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            acc            <= '0;
            _Data_Out      <= '0;
            _Data_Out_Load <= 1'b0;
            digit_count    <= 3'd0;
            entry_active   <= 1'b0;
            timeout_flag   <= 1'b0;
        end else begin
            _Data_Out_Load <= 1'b0;
            timeout_flag   <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        acc         <= '0;
                        digit_count <= 3'd0;
                    end else if (digit_load) begin
                        acc          <= ACC_W'(digit_in);
                        digit_count  <= 3'd1;
                        entry_active <= 1'b1;
                        state        <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (clear) begin
                        acc          <= '0;
                        digit_count  <= 3'd0;
                        entry_active <= 1'b0;
                        state        <= IDLE;
                    end else if (digit_load) begin
                        if (digit_count == 3'(NUM_DIGITS - 1)) begin
                            _Data_Out      <= build_word(op_sel, acc, digit_in);
                            _Data_Out_Load <= 1'b1;
                            acc            <= '0;
                            digit_count    <= 3'(NUM_DIGITS);
                            entry_active   <= 1'b0;
                            state          <= EMIT;
                        end else begin
                            acc         <= {acc[ACC_W-DIGIT_W-1:0], digit_in};
                            digit_count <= digit_count + 3'd1;
                        end
                    end else if (idle_done) begin
                        acc          <= '0;
                        digit_count  <= 3'd0;
                        entry_active <= 1'b0;
                        timeout_flag <= 1'b1;
                        state        <= IDLE;
                    end
                end
                EMIT: begin
                    digit_count <= 3'd0;
                    state       <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (hold_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_access_code_entry.sv
// Directed bench for access_code_entry with a strobe-driven scoreboard.
module tb_access_code_entry;
    import access_pkg::*;

    logic              clk;
    logic              rst;
    logic [3:0]        digit_in;
    logic              digit_load;
    logic [1:0]        op_sel;
    logic              clear;
    logic [17:0]       data_word;
    logic              data_load;
    logic [2:0]        digit_count;
    logic              entry_active;
    logic              timeout_flag;

    int checks;
    int errors;
    int strobes;
    int timeouts;
    logic [17:0] exp_q[$];

    access_code_entry #(
        .TIMEOUT_CYCLES (20),
        .HOLDOFF_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .digit_in       (digit_in),
        .digit_load     (digit_load),
        .op_sel         (op_sel),
        .clear          (clear),
        ._Data_Out      (data_word),
        ._Data_Out_Load (data_load),
        .digit_count    (digit_count),
        .entry_active   (entry_active),
        .timeout_flag   (timeout_flag)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every strobe must match the oldest expected word; timeout pulses are tallied.
    always @(negedge clk) begin
        if (rst && data_load) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_strobe got %05h expected no strobe", data_word);
            end else begin
                logic [17:0] want;
                want = exp_q.pop_front();
                if (data_word !== want) begin
                    errors++;
                    $display("[TB] FAIL strobe_word got %05h expected %05h", data_word, want);
                end
            end
        end
        if (rst && timeout_flag) timeouts++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Waits the given number of rising edges, then presents one digit for exactly one sampling edge.
    task automatic applyStimulus(input logic [3:0] d, input logic [1:0] op, input logic clr, input int wait_edges);
        repeat (wait_edges) @(posedge clk);
        #1;
        digit_in   = d;
        op_sel     = op;
        digit_load = 1'b1;
        clear      = clr;
        @(posedge clk);
        #1;
        digit_load = 1'b0;
        clear      = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; strobes = 0; timeouts = 0;
        rst = 1'b0; digit_in = 4'h0; digit_load = 1'b0; op_sel = 2'b00; clear = 1'b0;
        #3;
        checkOutput("reset_word", 32'(data_word), 32'h0);
        checkOutput("reset_load", 32'(data_load), 32'h0);
        checkOutput("reset_count", 32'(digit_count), 32'h0);
        checkOutput("reset_active", 32'(entry_active), 32'h0);
        checkOutput("reset_timeout", 32'(timeout_flag), 32'h0);
        #9 rst = 1'b1;

        $display("[TB] entry 1,2,3,4 op LOGIN");
        applyStimulus(4'h1, OP_LOGIN, 1'b0, 1);
        checkOutput("t1_count1", 32'(digit_count), 32'd1);
        checkOutput("t1_active", 32'(entry_active), 32'd1);
        applyStimulus(4'h2, OP_LOGIN, 1'b0, 1);
        checkOutput("t1_count2", 32'(digit_count), 32'd2);
        applyStimulus(4'h3, OP_LOGIN, 1'b0, 1);
        checkOutput("t1_count3", 32'(digit_count), 32'd3);
        checkOutput("t1_no_early_word", 32'(data_word), 32'h0);
        exp_q.push_back(18'h01234);
        applyStimulus(4'h4, OP_LOGIN, 1'b0, 1);
        checkOutput("t1_count4", 32'(digit_count), 32'd4);
        checkOutput("t1_strobe_now", 32'(data_load), 32'd1);
        checkOutput("t1_word", 32'(data_word), 32'h01234);
        @(posedge clk); #1;
        checkOutput("t1_count0", 32'(digit_count), 32'd0);
        checkOutput("t1_strobe_gone", 32'(data_load), 32'd0);
        repeat (10) @(posedge clk);

        $display("[TB] entry A,B,C,D op CHANGE then load during hold-off");
        applyStimulus(4'hA, OP_CHANGE, 1'b0, 1);
        applyStimulus(4'hB, OP_CHANGE, 1'b0, 1);
        applyStimulus(4'hC, OP_CHANGE, 1'b0, 1);
        exp_q.push_back(18'h1ABCD);
        applyStimulus(4'hD, OP_CHANGE, 1'b0, 1);
        checkOutput("t2_word", 32'(data_word), 32'h1ABCD);
        applyStimulus(4'h7, OP_LOGIN, 1'b0, 3);
        checkOutput("t2_holdoff_count", 32'(digit_count), 32'd0);
        checkOutput("t2_holdoff_active", 32'(entry_active), 32'd0);
        repeat (10) @(posedge clk); #1;
        checkOutput("t2_still_idle", 32'(digit_count), 32'd0);

        $display("[TB] timeout after two digits");
        applyStimulus(4'h5, OP_LOGOUT, 1'b0, 1);
        applyStimulus(4'h6, OP_LOGOUT, 1'b0, 1);
        repeat (19) @(posedge clk); #1;
        checkOutput("t3_before_count", 32'(digit_count), 32'd2);
        checkOutput("t3_before_flag", 32'(timeout_flag), 32'd0);
        @(posedge clk); #1;
        checkOutput("t3_flag", 32'(timeout_flag), 32'd1);
        checkOutput("t3_count", 32'(digit_count), 32'd0);
        checkOutput("t3_active", 32'(entry_active), 32'd0);
        checkOutput("t3_word_kept", 32'(data_word), 32'h1ABCD);
        @(posedge clk); #1;
        checkOutput("t3_flag_pulse", 32'(timeout_flag), 32'd0);

        $display("[TB] clear together with fourth digit");
        applyStimulus(4'h7, OP_RSVD, 1'b0, 2);
        applyStimulus(4'h8, OP_RSVD, 1'b0, 1);
        applyStimulus(4'h9, OP_RSVD, 1'b0, 1);
        checkOutput("t4_active_before", 32'(entry_active), 32'd1);
        applyStimulus(4'hE, OP_RSVD, 1'b1, 1);
        checkOutput("t4_count", 32'(digit_count), 32'd0);
        checkOutput("t4_active", 32'(entry_active), 32'd0);
        repeat (3) @(posedge clk); #1;
        checkOutput("t4_word_kept", 32'(data_word), 32'h1ABCD);

        $display("[TB] digit on the timeout cycle");
        applyStimulus(4'h3, OP_LOGIN, 1'b0, 1);
        applyStimulus(4'h4, OP_LOGIN, 1'b0, 19);
        checkOutput("t5_count", 32'(digit_count), 32'd2);
        checkOutput("t5_flag", 32'(timeout_flag), 32'd0);
        @(posedge clk); #1;
        checkOutput("t5_flag_after", 32'(timeout_flag), 32'd0);
        checkOutput("t5_active", 32'(entry_active), 32'd1);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checkOutput("t5_cleared", 32'(digit_count), 32'd0);

        $display("[TB] reset during emit");
        applyStimulus(4'h9, OP_LOGIN, 1'b0, 1);
        applyStimulus(4'h9, OP_LOGIN, 1'b0, 1);
        applyStimulus(4'h9, OP_LOGIN, 1'b0, 1);
        applyStimulus(4'h9, OP_LOGIN, 1'b0, 1);
        checkOutput("t6_in_emit", 32'(data_load), 32'd1);
        #1 rst = 1'b0;
        #1;
        checkOutput("t6_rst_word", 32'(data_word), 32'h0);
        checkOutput("t6_rst_load", 32'(data_load), 32'd0);
        checkOutput("t6_rst_count", 32'(digit_count), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        applyStimulus(4'h4, OP_LOGOUT, 1'b0, 1);
        applyStimulus(4'h3, OP_LOGOUT, 1'b0, 1);
        applyStimulus(4'h2, OP_LOGOUT, 1'b0, 1);
        exp_q.push_back(18'h24321);
        applyStimulus(4'h1, OP_LOGOUT, 1'b0, 1);
        checkOutput("t6_word", 32'(data_word), 32'h24321);
        repeat (12) @(posedge clk); #1;

        checkOutput("total_strobes", 32'(strobes), 32'd3);
        checkOutput("total_timeouts", 32'(timeouts), 32'd1);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/access_code_entry.md
Name: access_code_entry

Overview:
- Upstream stage that feeds the access-control block.
- Assembles four 4-bit keypad/switch digits and a 2-bit operation code into one 18-bit code word, then emits it with a single-cycle load strobe.
- Handles inactivity timeout, user clear and a post-emit hold-off, so the downstream comparator FSM only ever sees complete, well-spaced words.

Parameters:
- TIMEOUT_CYCLES, 50_000_000, idle cycles allowed between digits before a partial entry is discarded; valid range 2 to 2^32-1.
- HOLDOFF_CYCLES, 8, cycles after an emit during which digit_load is ignored; valid range 1 to 255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- digit_in  input  4  digit value; sampled only when digit_load=1.
- digit_load  input  1  one-cycle pulse from the button conditioner: accept digit_in.
- op_sel  input  2  operation code; sampled on the 4th accepted digit.
- clear  input  1  level; discards the partial entry.
- _Data_Out  output  18  code word: [17:16]=op, [15:12]=digit1, [11:8]=digit2, [7:4]=digit3, [3:0]=digit4.
- _Data_Out_Load  output  1  one-cycle strobe; _Data_Out is valid in the same cycle.
- digit_count  output  3  number of digits held, 0 to 4.
- entry_active  output  1  high while in COLLECT.
- timeout_flag  output  1  one-cycle pulse when a partial entry is discarded by timeout.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, shift register 0, counters 0, state IDLE.
- States:
  - IDLE: digit_load → shift digit into [3:0], digit_count=1, clear the idle counter → COLLECT.
  - COLLECT: each digit_load shifts the accumulator left by 4, inserts digit_in at [3:0], increments digit_count and clears the idle counter. The load that brings digit_count to 4 also captures op_sel into [17:16] → EMIT.
  - EMIT (exactly 1 cycle): _Data_Out_Load=1. _Data_Out already holds the word (registered on the 4th-digit edge). digit_count returns to 0 → HOLDOFF.
  - HOLDOFF: counter runs HOLDOFF_CYCLES cycles, digit_load is ignored, then → IDLE.
- Latency: 4th digit_load sampled at edge N → _Data_Out updated at N, _Data_Out_Load high during cycle N+1 only.
- _Data_Out holds its last emitted word until the next emit or reset; it never shows a partial entry. The accumulator is internal.
- Timeout: in COLLECT, the idle counter increments every cycle without digit_load. When it reaches TIMEOUT_CYCLES-1: state → IDLE, digit_count=0, accumulator cleared, timeout_flag=1 for one cycle.
- clear: in IDLE or COLLECT → IDLE, digit_count=0, accumulator cleared, no timeout_flag. In EMIT or HOLDOFF it is ignored; an emitted word is never retracted.
- Simultaneous events:
  - clear and digit_load in the same cycle: clear wins, digit dropped.
  - digit_load on the timeout cycle: the digit is accepted and timeout does not fire.
- All digit values 0x0 to 0xF are accepted; no decimal checking.
- Reset mid-entry or mid-emit aborts immediately; no strobe is produced afterward.
- Width rules: idle counter is 32 bits, hold-off counter is 8 bits, digit_count saturates logically at 4 (never exceeds).

Decomposition:
- Shared package access_pkg:
  - state encoding (IDLE=0, COLLECT=1, EMIT=2, HOLDOFF=3)
  - CODE_W=18, DIGIT_W=4, NUM_DIGITS=4, OP_W=2
  - op codes: OP_LOGIN=2'b00, OP_CHANGE=2'b01, OP_LOGOUT=2'b10, OP_RSVD=2'b11
- One natural sub-module: entry_timer, a loadable down-counter with a done pulse. It is instantiated twice: once for timeout, once for hold-off.

Test Plan:
- Reset then digits 1,2,3,4 with op_sel=00 → single _Data_Out_Load pulse one cycle after the 4th load, _Data_Out=18'h01234, digit_count sequence 1,2,3,4,0.
- Digits A,B,C,D with op_sel=01 → _Data_Out=18'h1ABCD; a digit_load issued 3 cycles after the strobe (HOLDOFF_CYCLES=8) is ignored and digit_count stays 0.
- TIMEOUT_CYCLES=20: enter 2 digits then idle 20 cycles → timeout_flag pulses once, digit_count=0, _Data_Out unchanged from the previous word, no strobe.
- Enter 3 digits, assert clear in the same cycle as the 4th digit_load → no strobe, digit_count=0, entry_active=0.
- Digit_load arriving exactly on the timeout cycle → accepted (digit_count increments), no timeout_flag.
- Assert rst low during EMIT → _Data_Out=0 and _Data_Out_Load=0 asynchronously; after release, a fresh 4-digit entry emits normally.
